// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every signal that passes through the data-memory arbiter: the two
// requester handshakes, the shared read-return bus, the core stall and the
// single data_mem port.
//
//   slave  : arbiter view. It samples requests and mem_rdata, and drives the
//            grants, the read return, stall_core and the mem_* strobes.
//   master : environment view. This is the MEM stage, the DMA loader and
//            data_mem seen together, as a bench or wrapper sees them.
//
// Signals
//   req0/1, we0/1, addr0/1, wdata0/1   requester payloads
//   gnt0/1                             access performed this cycle
//   rvalid0/1, rdata                   registered read return, shared data
//   stall_core                         core request pending but not granted
//   mem_MemRead, mem_MemWrite,
//   mem_addr, mem_wdata                drive to data_mem
//   mem_rdata                          combinational read data from data_mem
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [DM_ADDRESS-1:0] addr0;
  logic [DM_ADDRESS-1:0] addr1;
  logic [DATA_W-1:0]     wdata0;
  logic [DATA_W-1:0]     wdata1;

  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_W-1:0]     rdata;
  logic                  stall_core;

  logic                  mem_MemRead;
  logic                  mem_MemWrite;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, stall_core,
           mem_MemRead, mem_MemWrite, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, stall_core,
           mem_MemRead, mem_MemWrite, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data_mem port between the core load/store stage
// (requester 0) and the preload DMA (requester 1). At most one access is
// granted per cycle. The grant and the memory strobes are combinational from
// the requests and the arbitration state. Read data is captured at the edge
// that ends the granted read and returned one cycle later on a shared rdata
// bus, with a per-requester rvalid.
//
// Parameters
//   DATA_W        data width
//   DM_ADDRESS    data memory address width
//   FIXED_PRIO    1: requester 0 wins contention, with a starvation guard
//                    for requester 1
//                 0: pure round-robin
//   STARVE_LIMIT  consecutive denials of requester 1 before it is forced a
//                 grant (FIXED_PRIO=1 only), 1..15
//
// Ports
//   clk     clock
//   reset   synchronous, active-high
//   bus     dmem_arbiter_if.slave, carrying requests, grants, the read
//           return, stall_core and the data_mem port
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int DM_ADDRESS   = 9,
  parameter int FIXED_PRIO   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_arbiter_if.slave        bus
);

  localparam logic [3:0] STARVE_LIM4 = STARVE_LIMIT[3:0];

  // Arbitration state
  logic              r_last;        // index of the most recent grant
  logic [3:0]        r_starve_cnt;  // consecutive denials of requester 1

  // Read-return stage
  logic              r_vld0_p1;
  logic              r_vld1_p1;
  logic [DATA_W-1:0] r_rdata_p1;

  // Grant-cycle wires
  logic              w_any;
  logic              w_both;
  logic              w_starved;
  logic              w_sel;         // 1 selects requester 1
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_we;
  logic              w_rd_gnt0;
  logic              w_rd_gnt1;
  logic [3:0]        w_starve_nxt;

  // Saturating increment of the starvation counter; it stops at the limit
  // so the forced grant stays pending until requester 1 is actually served.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    if (c >= STARVE_LIM4) begin
      return STARVE_LIM4;
    end
    return c + 4'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // p0: grant selection and memory drive (combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_any     = bus.req0 | bus.req1;
    w_both    = bus.req0 & bus.req1;
    w_starved = (r_starve_cnt == STARVE_LIM4);
    w_sel     = 1'b0;
    if (w_both) begin
      if (FIXED_PRIO != 0) begin
        w_sel = w_starved;
      end else begin
        // Round-robin: the requester that did not win last time.
        w_sel = ~r_last;
      end
    end else begin
      w_sel = bus.req1;
    end
    w_gnt0 = w_any & ~w_sel;
    w_gnt1 = w_any &  w_sel;
  end

  // With no request w_sel stays 0, so the address and data buses show
  // requester 0's values while both strobes are low.
  always_comb begin
    w_we              = w_sel ? bus.we1 : bus.we0;
    bus.mem_addr      = w_sel ? bus.addr1  : bus.addr0;
    bus.mem_wdata     = w_sel ? bus.wdata1 : bus.wdata0;
    bus.mem_MemWrite  = w_any &  w_we;
    bus.mem_MemRead   = w_any & ~w_we;
    w_rd_gnt0         = w_gnt0 & ~bus.we0;
    w_rd_gnt1         = w_gnt1 & ~bus.we1;
  end

  always_comb begin
    w_starve_nxt = 4'd0;
    if (bus.req1 && !w_gnt1) begin
      w_starve_nxt = sat_inc(r_starve_cnt);
    end
  end

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.stall_core = bus.req0 & ~w_gnt0;

  // ---------------------------------------------------------------------------
  // p0 -> p1: arbitration state and registered read return
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // last=1 so requester 0 wins the first contention in round-robin mode.
      r_last       <= 1'b1;
      r_starve_cnt <= 4'd0;
      r_vld0_p1    <= 1'b0;
      r_vld1_p1    <= 1'b0;
      r_rdata_p1   <= '0;
    end else begin
      if (w_any) begin
        r_last <= w_sel;
      end
      r_starve_cnt <= w_starve_nxt;
      r_vld0_p1    <= w_rd_gnt0;
      r_vld1_p1    <= w_rd_gnt1;
      // rdata is held between reads so a late consumer still sees it.
      if (w_rd_gnt0 || w_rd_gnt1) begin
        r_rdata_p1 <= bus.mem_rdata;
      end
    end
  end

  assign bus.rvalid0 = r_vld0_p1;
  assign bus.rvalid1 = r_vld1_p1;
  assign bus.rdata   = r_rdata_p1;

endmodule
